vx_csr_exec_pipe: RTL and testbench
===================================

Name: vx_csr_exec_pipe

Overview:
- Parametrised CSR execute pipeline for one core.
- Arbitrates between core CSR instructions and the host I/O CSR port, then performs the read-modify-write (RW/RS/RC) against an external CSR storage block.
- Carries results through a configurable-depth pipeline with full forwarding, and returns per-thread writeback data or an I/O response.
- Sits between issue/dispatch and commit. It adds fair arbitration, per-warp in-flight counters, a read-only-range write guard and a configurable depth.

Parameters:
- XLEN, 32, CSR data width
- CSR_ADDR_BITS, 12, CSR address width
- NUM_WARPS, 4, warps per core
- NUM_THREADS, 4, threads per warp
- PIPE_DEPTH, 2, stages from accept to response (1..4)
- RO_BASE, 12'hC00, first read-only CSR address
- RO_LIMIT, 12'hCFF, last read-only CSR address (inclusive)
- MAX_INFLIGHT, 3, per-warp outstanding-op limit

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- core_req_valid / core_req_ready  in/out  1  core request handshake
- core_req_wid  in  log2(NUM_WARPS)  warp id
- core_req_tmask  in  NUM_THREADS  thread mask
- core_req_pc  in  32  instruction PC
- core_req_rd  in  5  destination register
- core_req_wb  in  1  writeback enable
- core_req_op  in  2  0=RW, 1=RS, 2=RC, 3=reserved (treated as read-only, no write)
- core_req_addr  in  CSR_ADDR_BITS  CSR address
- core_req_data  in  XLEN  operand
- io_req_valid / io_req_ready  in/out  1  host I/O request handshake
- io_req_rw  in  1  1=write (RW), 0=read
- io_req_addr  in  CSR_ADDR_BITS  CSR address
- io_req_data  in  XLEN  write data
- io_rsp_valid / io_rsp_ready  out/in  1  I/O response handshake
- io_rsp_data  out  XLEN  old CSR value
- cmt_valid / cmt_ready  out/in  1  commit handshake
- cmt_wid, cmt_tmask, cmt_pc, cmt_rd, cmt_wb  out  as request  echoed fields
- cmt_data  out  NUM_THREADS*XLEN  per-thread result
- cmt_eop  out  1  constant 1
- cmt_illegal  out  1  write attempted to read-only CSR
- csr_rd_en  out  1  storage read enable
- csr_rd_addr  out  CSR_ADDR_BITS  storage read address
- csr_rd_wid  out  log2(NUM_WARPS)  storage read warp
- csr_rd_data  in  XLEN  combinational read data
- csr_wr_en  out  1  storage write enable
- csr_wr_addr  out  CSR_ADDR_BITS  storage write address
- csr_wr_wid  out  log2(NUM_WARPS)  storage write warp
- csr_wr_data  out  XLEN  storage write data
- fpu_pending  in  NUM_WARPS  per-warp FPU ops outstanding
- pending  out  NUM_WARPS  warp has CSR ops in flight

Behaviour:
- Reset: all stage valids 0; pending 0; all counters 0; arbiter pointer points to core; all valid outputs 0.
- Core stall condition: fpu_pending[wid], or the warp's counter equals MAX_INFLIGHT. The stall blocks only core requests.
- Arbitration:
  - A request is eligible if it is valid and, for core requests, not stalled.
  - If only one is eligible, it wins.
  - If both are eligible, round-robin: the pointer toggles after each granted conflict.
- Accept: at most one request per cycle, and only when stage 0 is free or advancing (global enable = !(last_valid && !out_ready)).
  - out_ready is cmt_ready for core ops and io_rsp_ready for I/O ops.
- Read: csr_rd_* is driven in the accept cycle. I/O requests use wid 0.
- Forwarding: the read value is replaced by the new value of the youngest in-flight stage with matching addr, matching wid and write enable set.
- New value:
  - RW: operand.
  - RS: old | operand.
  - RC: old & ~operand.
- Write enable:
  - RW: always.
  - RS and RC: only if operand != 0.
  - Reserved op: never.
- Read-only guard: if the address is in [RO_BASE, RO_LIMIT] and write enable is set, suppress the write and set illegal=1.
- Latency: exactly PIPE_DEPTH cycles from accept to response valid when there is no back-pressure. Back-pressure freezes all stages.
- Storage write: csr_wr_en is asserted in the cycle the last stage handshakes (valid && out_ready), once per op.
- Per-thread commit data:
  - addr CSR_WTID: thread index i.
  - addr CSR_LTID or CSR_GTID: old*NUM_THREADS + i.
  - Otherwise: old, replicated per thread.
- Counters: per-warp counter increments on core accept and decrements on core commit fire. If both happen in the same cycle for the same warp, the counter is unchanged. pending[w] = (counter != 0).
- Mid-operation reset: all in-flight ops are dropped, no storage write occurs, and counters clear.

Decomposition:
- Shared package (VX_define.vh additions): CSR op encodings, CSR_WTID/LTID/GTID, the RO range defaults, and the stage payload struct (wid, tmask, pc, rd, wb, we, addr, is_io, illegal, old, new).
- One sub-module: vx_csr_rr_arb, a two-way round-robin arbiter with a stall qualifier.

Test Plan:
1. Reset, then a core RW to addr 0x300 with data 5, PIPE_DEPTH=2 → cmt_valid at cycle+2 with old value; csr_wr_en once with data 5; pending[wid] is 1 during flight, then 0.
2. Back-to-back core RS of 0x1 then 0x2 to the same addr and wid (initial 0) → second op reads forwarded value 1; final write is 3.
3. Core and I/O valid for 4 cycles with both ready → grants alternate core, io, core, io.
4. fpu_pending[1]=1 with a core req from wid 1 and an I/O req present → I/O is accepted; core stays stalled until fpu_pending[1]=0.
5. Core RW to 0xC00 with data 7 → cmt_illegal=1; no csr_wr_en; old value returned.
6. Read of CSR_LTID with old=2, NUM_THREADS=4, and cmt_ready held low for 3 cycles → response held stable; data {8,9,10,11}; single write-free completion.

Source files
------------

// File: rtl/vx_csr_exec_pipe_pkg.sv
// vx_csr_exec_pipe_pkg
// Shared definitions for the CSR execute pipeline: CSR op encodings, the
// thread-id CSR addresses, the default read-only CSR window, and a helper that
// decides whether an op writes the CSR.
// The stage payload struct lives inside vx_csr_exec_pipe because its field
// widths follow that module's parameters (XLEN, NUM_THREADS, ...).

package vx_csr_exec_pipe_pkg;

    typedef enum logic [1:0] {
        CSR_OP_RW   = 2'd0,
        CSR_OP_RS   = 2'd1,
        CSR_OP_RC   = 2'd2,
        CSR_OP_RSVD = 2'd3
    } csr_op_e;

    // Thread-id CSRs whose commit data is synthesised per thread
    localparam logic [11:0] CSR_WTID = 12'hCC0;
    localparam logic [11:0] CSR_LTID = 12'hCC1;
    localparam logic [11:0] CSR_GTID = 12'hCC2;

    // Default read-only CSR window (inclusive on both ends)
    localparam logic [11:0] RO_BASE_DEF  = 12'hC00;
    localparam logic [11:0] RO_LIMIT_DEF = 12'hCFF;

    // RS/RC with a zero operand are pure reads and must not touch storage
    function automatic logic csr_op_writes(input csr_op_e op, input logic operand_nz);
        case (op)
            CSR_OP_RW: csr_op_writes = 1'b1;
            CSR_OP_RS: csr_op_writes = operand_nz;
            CSR_OP_RC: csr_op_writes = operand_nz;
            default:   csr_op_writes = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vx_csr_exec_pipe_rr_arb.sv
// vx_csr_rr_arb
// Two-way round-robin arbiter between core CSR requests and the host I/O port.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   core_valid, core_stall core request and its stall qualifier
//   io_valid               I/O request
//   advance                pipeline can accept this cycle
//   grant_core, grant_io   one-hot (or zero) grant

module vx_csr_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic core_valid,
    input  logic core_stall,
    input  logic io_valid,
    input  logic advance,
    output logic grant_core,
    output logic grant_io
);

    logic prefer_io;
    logic core_elig;

    assign core_elig  = core_valid && !core_stall;
    assign grant_core = core_elig && (!io_valid || !prefer_io);
    assign grant_io   = io_valid && (!core_elig || prefer_io);

    // Pointer only moves when a real conflict was actually accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            prefer_io <= 1'b0;
        end else if (advance && core_elig && io_valid) begin
            prefer_io <= !prefer_io;
        end
    end

endmodule

// File: rtl/vx_csr_exec_pipe.sv
// vx_csr_exec_pipe
// CSR execute pipeline for one core. Arbitrates core CSR instructions against
// the host I/O CSR port, reads external CSR storage in the accept cycle (with
// forwarding from in-flight writes), computes the RW/RS/RC result, and carries
// it through PIPE_DEPTH stages to either the commit port or the I/O response.
// The storage write happens when the last stage hands off.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   core_req_*                 core CSR instruction (valid/ready)
//   io_req_*                   host I/O CSR access (valid/ready)
//   io_rsp_*                   host I/O response, returns old CSR value
//   cmt_*                      commit of core ops, per-thread result data
//   csr_rd_*, csr_wr_*         external CSR storage (combinational read)
//   fpu_pending                per-warp FPU ops outstanding (stalls core ops)
//   pending                    per-warp CSR ops in flight

module vx_csr_exec_pipe
    import vx_csr_exec_pipe_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int CSR_ADDR_BITS = 12,
    parameter int NUM_WARPS     = 4,
    parameter int NUM_THREADS   = 4,
    parameter int PIPE_DEPTH    = 2,
    parameter logic [CSR_ADDR_BITS-1:0] RO_BASE  = CSR_ADDR_BITS'(RO_BASE_DEF),
    parameter logic [CSR_ADDR_BITS-1:0] RO_LIMIT = CSR_ADDR_BITS'(RO_LIMIT_DEF),
    parameter int MAX_INFLIGHT  = 3,
    localparam int WID_W        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          core_req_valid,
    output logic                          core_req_ready,
    input  logic [WID_W-1:0]              core_req_wid,
    input  logic [NUM_THREADS-1:0]        core_req_tmask,
    input  logic [31:0]                   core_req_pc,
    input  logic [4:0]                    core_req_rd,
    input  logic                          core_req_wb,
    input  logic [1:0]                    core_req_op,
    input  logic [CSR_ADDR_BITS-1:0]      core_req_addr,
    input  logic [XLEN-1:0]               core_req_data,
    input  logic                          io_req_valid,
    output logic                          io_req_ready,
    input  logic                          io_req_rw,
    input  logic [CSR_ADDR_BITS-1:0]      io_req_addr,
    input  logic [XLEN-1:0]               io_req_data,
    output logic                          io_rsp_valid,
    input  logic                          io_rsp_ready,
    output logic [XLEN-1:0]               io_rsp_data,
    output logic                          cmt_valid,
    input  logic                          cmt_ready,
    output logic [WID_W-1:0]              cmt_wid,
    output logic [NUM_THREADS-1:0]        cmt_tmask,
    output logic [31:0]                   cmt_pc,
    output logic [4:0]                    cmt_rd,
    output logic                          cmt_wb,
    output logic [NUM_THREADS*XLEN-1:0]   cmt_data,
    output logic                          cmt_eop,
    output logic                          cmt_illegal,
    output logic                          csr_rd_en,
    output logic [CSR_ADDR_BITS-1:0]      csr_rd_addr,
    output logic [WID_W-1:0]              csr_rd_wid,
    input  logic [XLEN-1:0]               csr_rd_data,
    output logic                          csr_wr_en,
    output logic [CSR_ADDR_BITS-1:0]      csr_wr_addr,
    output logic [WID_W-1:0]              csr_wr_wid,
    output logic [XLEN-1:0]               csr_wr_data,
    input  logic [NUM_WARPS-1:0]          fpu_pending,
    output logic [NUM_WARPS-1:0]          pending
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int LAST  = PIPE_DEPTH - 1;

    typedef struct packed {
        logic [WID_W-1:0]         wid;
        logic [NUM_THREADS-1:0]   tmask;
        logic [31:0]              pc;
        logic [4:0]               rd;
        logic                     wb;
        logic                     we;
        logic [CSR_ADDR_BITS-1:0] addr;
        logic                     is_io;
        logic                     illegal;
        logic [XLEN-1:0]          old_val;
        logic [XLEN-1:0]          new_val;
    } stage_t;

    stage_t                  stg [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0]   stg_valid;
    logic [CNT_W-1:0]        inflight [NUM_WARPS];
    logic [NUM_WARPS-1:0]    cnt_inc;
    logic [NUM_WARPS-1:0]    cnt_dec;

    logic                     last_valid;
    logic                     out_ready;
    logic                     advance;
    logic                     fire;
    logic                     core_stall;
    logic                     grant_core;
    logic                     grant_io;
    logic                     core_fire;
    logic                     io_fire;
    csr_op_e                  acc_op;
    logic [XLEN-1:0]          acc_operand;
    logic [CSR_ADDR_BITS-1:0] acc_addr;
    logic [WID_W-1:0]         acc_wid;
    logic [XLEN-1:0]          acc_old;
    logic [XLEN-1:0]          acc_new;
    logic                     acc_we_raw;
    logic                     acc_in_ro;
    stage_t                   acc_stage;

    // Whole pipeline freezes only when the last stage holds an unaccepted result
    assign last_valid = stg_valid[LAST];
    assign out_ready  = stg[LAST].is_io ? io_rsp_ready : cmt_ready;
    assign advance    = !(last_valid && !out_ready);
    assign fire       = last_valid && out_ready;

    assign core_stall = fpu_pending[core_req_wid] ||
                        (inflight[core_req_wid] == CNT_W'(MAX_INFLIGHT));

    vx_csr_rr_arb arb (
        .clk        (clk),
        .reset      (reset),
        .core_valid (core_req_valid),
        .core_stall (core_stall),
        .io_valid   (io_req_valid),
        .advance    (advance),
        .grant_core (grant_core),
        .grant_io   (grant_io)
    );

    assign core_fire      = grant_core && advance;
    assign io_fire        = grant_io && advance;
    assign core_req_ready = core_fire;
    assign io_req_ready   = io_fire;

    // I/O reads map onto the reserved op so they never write; I/O always uses warp 0
    always_comb begin
        acc_op      = csr_op_e'(core_req_op);
        acc_operand = core_req_data;
        acc_addr    = core_req_addr;
        acc_wid     = core_req_wid;
        if (grant_io) begin
            acc_op      = io_req_rw ? CSR_OP_RW : CSR_OP_RSVD;
            acc_operand = io_req_data;
            acc_addr    = io_req_addr;
            acc_wid     = '0;
        end
    end

    assign csr_rd_en   = core_fire || io_fire;
    assign csr_rd_addr = acc_addr;
    assign csr_rd_wid  = acc_wid;

    // Walk oldest to youngest so the youngest matching writer wins
    always_comb begin
        acc_old = csr_rd_data;
        for (int i = LAST; i >= 0; i--) begin
            if (stg_valid[i] && stg[i].we && stg[i].addr == acc_addr && stg[i].wid == acc_wid) begin
                acc_old = stg[i].new_val;
            end
        end
    end

    always_comb begin
        case (acc_op)
            CSR_OP_RW: acc_new = acc_operand;
            CSR_OP_RS: acc_new = acc_old | acc_operand;
            CSR_OP_RC: acc_new = acc_old & ~acc_operand;
            default:   acc_new = acc_old;
        endcase
    end

    assign acc_we_raw = csr_op_writes(acc_op, acc_operand != '0);
    assign acc_in_ro  = (acc_addr >= RO_BASE) && (acc_addr <= RO_LIMIT);

    // Stored we is the effective write, so forwarding ignores suppressed writes
    always_comb begin
        acc_stage         = '0;
        acc_stage.wid     = acc_wid;
        acc_stage.addr    = acc_addr;
        acc_stage.is_io   = grant_io;
        acc_stage.we      = acc_we_raw && !acc_in_ro;
        acc_stage.illegal = acc_we_raw && acc_in_ro;
        acc_stage.old_val = acc_old;
        acc_stage.new_val = acc_new;
        if (!grant_io) begin
            acc_stage.tmask = core_req_tmask;
            acc_stage.pc    = core_req_pc;
            acc_stage.rd    = core_req_rd;
            acc_stage.wb    = core_req_wb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid <= '0;
        end else if (advance) begin
            stg_valid[0] <= core_fire || io_fire;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                stg_valid[i] <= stg_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            stg[0] <= acc_stage;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            cnt_inc[w] = core_fire && (core_req_wid == WID_W'(w));
            cnt_dec[w] = fire && !stg[LAST].is_io && (stg[LAST].wid == WID_W'(w));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                inflight[w] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (cnt_inc[w] && !cnt_dec[w]) begin
                    inflight[w] <= inflight[w] + 1'b1;
                end else if (cnt_dec[w] && !cnt_inc[w]) begin
                    inflight[w] <= inflight[w] - 1'b1;
                end
            end
        end
    end

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_pending
        assign pending[w] = (inflight[w] != '0);
    end

    // Thread-id CSRs are expanded per lane; everything else is broadcast
    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
        logic [XLEN-1:0] lane_data;
        always_comb begin
            if (stg[LAST].addr == CSR_ADDR_BITS'(CSR_WTID)) begin
                lane_data = XLEN'(t);
            end else if (stg[LAST].addr == CSR_ADDR_BITS'(CSR_LTID) ||
                         stg[LAST].addr == CSR_ADDR_BITS'(CSR_GTID)) begin
                lane_data = stg[LAST].old_val * XLEN'(NUM_THREADS) + XLEN'(t);
            end else begin
                lane_data = stg[LAST].old_val;
            end
        end
        assign cmt_data[t*XLEN +: XLEN] = lane_data;
    end

    assign cmt_valid    = last_valid && !stg[LAST].is_io;
    assign cmt_wid      = stg[LAST].wid;
    assign cmt_tmask    = stg[LAST].tmask;
    assign cmt_pc       = stg[LAST].pc;
    assign cmt_rd       = stg[LAST].rd;
    assign cmt_wb       = stg[LAST].wb;
    assign cmt_eop      = 1'b1;
    assign cmt_illegal  = stg[LAST].illegal;

    assign io_rsp_valid = last_valid && stg[LAST].is_io;
    assign io_rsp_data  = stg[LAST].old_val;

    assign csr_wr_en    = fire && stg[LAST].we;
    assign csr_wr_addr  = stg[LAST].addr;
    assign csr_wr_wid   = stg[LAST].wid;
    assign csr_wr_data  = stg[LAST].new_val;

endmodule

// File: tb/tb_vx_csr_exec_pipe.sv
// tb_vx_csr_exec_pipe
// Directed bench for vx_csr_exec_pipe with default parameters (PIPE_DEPTH=2).
// Provides a small CSR storage array with preset contents, drives inputs on
// the falling edge and checks outputs a moment later against hand-computed values.

module tb_vx_csr_exec_pipe;

    localparam int XLEN = 32;
    localparam int NT   = 4;
    localparam int NW   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            core_req_valid;
    logic            core_req_ready;
    logic [1:0]      core_req_wid;
    logic [NT-1:0]   core_req_tmask;
    logic [31:0]     core_req_pc;
    logic [4:0]      core_req_rd;
    logic            core_req_wb;
    logic [1:0]      core_req_op;
    logic [11:0]     core_req_addr;
    logic [31:0]     core_req_data;
    logic            io_req_valid;
    logic            io_req_ready;
    logic            io_req_rw;
    logic [11:0]     io_req_addr;
    logic [31:0]     io_req_data;
    logic            io_rsp_valid;
    logic            io_rsp_ready;
    logic [31:0]     io_rsp_data;
    logic            cmt_valid;
    logic            cmt_ready;
    logic [1:0]      cmt_wid;
    logic [NT-1:0]   cmt_tmask;
    logic [31:0]     cmt_pc;
    logic [4:0]      cmt_rd;
    logic            cmt_wb;
    logic [NT*XLEN-1:0] cmt_data;
    logic            cmt_eop;
    logic            cmt_illegal;
    logic            csr_rd_en;
    logic [11:0]     csr_rd_addr;
    logic [1:0]      csr_rd_wid;
    logic [31:0]     csr_rd_data;
    logic            csr_wr_en;
    logic [11:0]     csr_wr_addr;
    logic [1:0]      csr_wr_wid;
    logic [31:0]     csr_wr_data;
    logic [NW-1:0]   fpu_pending;
    logic [NW-1:0]   pending;

    bit [31:0] mem [NW][4096];
    int        wr_count = 0;
    int        grant_q[$];
    int        checks = 0;
    int        errors = 0;
    int        wr_base;
    int        gstart;

    vx_csr_exec_pipe dut (
        .clk            (clk),
        .reset          (reset),
        .core_req_valid (core_req_valid),
        .core_req_ready (core_req_ready),
        .core_req_wid   (core_req_wid),
        .core_req_tmask (core_req_tmask),
        .core_req_pc    (core_req_pc),
        .core_req_rd    (core_req_rd),
        .core_req_wb    (core_req_wb),
        .core_req_op    (core_req_op),
        .core_req_addr  (core_req_addr),
        .core_req_data  (core_req_data),
        .io_req_valid   (io_req_valid),
        .io_req_ready   (io_req_ready),
        .io_req_rw      (io_req_rw),
        .io_req_addr    (io_req_addr),
        .io_req_data    (io_req_data),
        .io_rsp_valid   (io_rsp_valid),
        .io_rsp_ready   (io_rsp_ready),
        .io_rsp_data    (io_rsp_data),
        .cmt_valid      (cmt_valid),
        .cmt_ready      (cmt_ready),
        .cmt_wid        (cmt_wid),
        .cmt_tmask      (cmt_tmask),
        .cmt_pc         (cmt_pc),
        .cmt_rd         (cmt_rd),
        .cmt_wb         (cmt_wb),
        .cmt_data       (cmt_data),
        .cmt_eop        (cmt_eop),
        .cmt_illegal    (cmt_illegal),
        .csr_rd_en      (csr_rd_en),
        .csr_rd_addr    (csr_rd_addr),
        .csr_rd_wid     (csr_rd_wid),
        .csr_rd_data    (csr_rd_data),
        .csr_wr_en      (csr_wr_en),
        .csr_wr_addr    (csr_wr_addr),
        .csr_wr_wid     (csr_wr_wid),
        .csr_wr_data    (csr_wr_data),
        .fpu_pending    (fpu_pending),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    // CSR storage: combinational read, write on the clock edge, preset during reset
    assign csr_rd_data = mem[csr_rd_wid][csr_rd_addr];

    always @(posedge clk) begin
        if (reset) begin
            mem[0][12'h306] <= 32'hABCD;
            mem[2][12'h300] <= 32'h11;
            mem[3][12'hC00] <= 32'h42;
            mem[1][12'hCC1] <= 32'd2;
        end else if (csr_wr_en) begin
            mem[csr_wr_wid][csr_wr_addr] <= csr_wr_data;
            wr_count <= wr_count + 1;
        end
    end

    // Accepted-request log: 1 = core, 2 = I/O
    always @(posedge clk) begin
        if (!reset) begin
            if (core_req_valid && core_req_ready) grant_q.push_back(1);
            if (io_req_valid && io_req_ready)     grant_q.push_back(2);
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] wid, input logic [NT-1:0] tmask,
                                 input logic [31:0] pc, input logic [4:0] rd,
                                 input logic wb, input logic [1:0] op,
                                 input logic [11:0] addr, input logic [31:0] data);
        core_req_valid = 1'b1;
        core_req_wid   = wid;
        core_req_tmask = tmask;
        core_req_pc    = pc;
        core_req_rd    = rd;
        core_req_wb    = wb;
        core_req_op    = op;
        core_req_addr  = addr;
        core_req_data  = data;
    endtask

    task automatic applyIdle();
        core_req_valid = 1'b0;
        core_req_wid   = '0;
        core_req_tmask = '0;
        core_req_pc    = '0;
        core_req_rd    = '0;
        core_req_wb    = 1'b0;
        core_req_op    = '0;
        core_req_addr  = '0;
        core_req_data  = '0;
        io_req_valid   = 1'b0;
        io_req_rw      = 1'b0;
        io_req_addr    = '0;
        io_req_data    = '0;
    endtask

    initial begin
        reset        = 1'b1;
        cmt_ready    = 1'b1;
        io_rsp_ready = 1'b1;
        fpu_pending  = '0;
        applyIdle();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_cmt_valid", cmt_valid, 0);
        checkOutput("rst_io_rsp_valid", io_rsp_valid, 0);
        checkOutput("rst_pending", pending, 0);
        checkOutput("rst_wr_en", csr_wr_en, 0);
        checkOutput("rst_core_ready", core_req_ready, 0);

        // Single core RW, warp 2, addr 0x300 (old 0x11) <- 5
        @(negedge clk);
        applyStimulus(2'd2, 4'b1011, 32'h1000, 5'd7, 1'b1, 2'd0, 12'h300, 32'd5);
        wr_base = wr_count;
        #1;
        checkOutput("t1_ready", core_req_ready, 1);
        checkOutput("t1_rd_en", csr_rd_en, 1);
        checkOutput("t1_rd_addr", csr_rd_addr, 12'h300);
        @(negedge clk);
        applyIdle();
        #1;
        checkOutput("t1_pending_flight", pending[2], 1);
        checkOutput("t1_cmt_not_early", cmt_valid, 0);
        @(negedge clk);
        #1;
        checkOutput("t1_cmt_valid", cmt_valid, 1);
        checkOutput("t1_cmt_data", cmt_data, {4{32'h11}});
        checkOutput("t1_cmt_wid", cmt_wid, 2);
        checkOutput("t1_cmt_tmask", cmt_tmask, 4'b1011);
        checkOutput("t1_cmt_pc", cmt_pc, 32'h1000);
        checkOutput("t1_cmt_rd", cmt_rd, 7);
        checkOutput("t1_cmt_wb", cmt_wb, 1);
        checkOutput("t1_cmt_eop", cmt_eop, 1);
        checkOutput("t1_cmt_illegal", cmt_illegal, 0);
        checkOutput("t1_wr_en", csr_wr_en, 1);
        checkOutput("t1_wr_data", csr_wr_data, 5);
        checkOutput("t1_wr_addr", csr_wr_addr, 12'h300);
        checkOutput("t1_pending_last", pending[2], 1);
        @(negedge clk);
        #1;
        checkOutput("t1_cmt_done", cmt_valid, 0);
        checkOutput("t1_pending_clear", pending[2], 0);
        checkOutput("t1_write_count", wr_count - wr_base, 1);
        checkOutput("t1_storage", mem[2][12'h300], 5);

        // Back-to-back RS 1 then RS 2 on warp 1, addr 0x340 (old 0): forwarding
        @(negedge clk);
        applyStimulus(2'd1, 4'hF, 32'h2000, 5'd3, 1'b1, 2'd1, 12'h340, 32'd1);
        wr_base = wr_count;
        @(negedge clk);
        applyStimulus(2'd1, 4'hF, 32'h2004, 5'd4, 1'b1, 2'd1, 12'h340, 32'd2);
        #1;
        checkOutput("t2_second_ready", core_req_ready, 1);
        @(negedge clk);
        applyIdle();
        #1;
        checkOutput("t2_a_data", cmt_data, {4{32'd0}});
        checkOutput("t2_a_wr_data", csr_wr_data, 1);
        @(negedge clk);
        #1;
        checkOutput("t2_b_valid", cmt_valid, 1);
        checkOutput("t2_b_fwd_old", cmt_data, {4{32'd1}});
        checkOutput("t2_b_wr_data", csr_wr_data, 3);
        checkOutput("t2_b_pc", cmt_pc, 32'h2004);
        @(negedge clk);
        #1;
        checkOutput("t2_write_count", wr_count - wr_base, 2);
        checkOutput("t2_storage", mem[1][12'h340], 3);

        // Core and I/O both valid for 4 cycles: grants alternate
        @(negedge clk);
        gstart = grant_q.size();
        applyStimulus(2'd0, 4'h1, 32'h3000, 5'd1, 1'b1, 2'd0, 12'h305, 32'd9);
        io_req_valid = 1'b1;
        io_req_rw    = 1'b0;
        io_req_addr  = 12'h306;
        repeat (4) @(negedge clk);
        applyIdle();
        repeat (3) @(negedge clk);
        checkOutput("t3_grant_count", grant_q.size() - gstart, 4);
        if (grant_q.size() - gstart >= 4) begin
            checkOutput("t3_grant0", grant_q[gstart],   1);
            checkOutput("t3_grant1", grant_q[gstart+1], 2);
            checkOutput("t3_grant2", grant_q[gstart+2], 1);
            checkOutput("t3_grant3", grant_q[gstart+3], 2);
        end
        checkOutput("t3_pending_drained", pending, 0);

        // FPU stall on warp 1 blocks core only; I/O goes through
        @(negedge clk);
        fpu_pending = 4'b0010;
        applyStimulus(2'd1, 4'h3, 32'h4000, 5'd2, 1'b1, 2'd0, 12'h341, 32'd9);
        io_req_valid = 1'b1;
        io_req_rw    = 1'b0;
        io_req_addr  = 12'h306;
        #1;
        checkOutput("t4_core_stalled", core_req_ready, 0);
        checkOutput("t4_io_ready", io_req_ready, 1);
        @(negedge clk);
        io_req_valid = 1'b0;
        #1;
        checkOutput("t4_core_still_stalled", core_req_ready, 0);
        @(negedge clk);
        #1;
        checkOutput("t4_io_rsp_valid", io_rsp_valid, 1);
        checkOutput("t4_io_rsp_data", io_rsp_data, 32'hABCD);
        checkOutput("t4_no_cmt", cmt_valid, 0);
        checkOutput("t4_core_stalled_late", core_req_ready, 0);
        @(negedge clk);
        fpu_pending = '0;
        #1;
        checkOutput("t4_core_released", core_req_ready, 1);
        @(negedge clk);
        applyIdle();
        repeat (3) @(negedge clk);

        // RW to read-only 0xC00: illegal, no write, old value returned
        wr_base = wr_count;
        applyStimulus(2'd3, 4'hF, 32'h5000, 5'd5, 1'b1, 2'd0, 12'hC00, 32'd7);
        @(negedge clk);
        applyIdle();
        @(negedge clk);
        #1;
        checkOutput("t5_cmt_valid", cmt_valid, 1);
        checkOutput("t5_illegal", cmt_illegal, 1);
        checkOutput("t5_no_wr_en", csr_wr_en, 0);
        checkOutput("t5_old", cmt_data, {4{32'h42}});
        repeat (2) @(negedge clk);
        checkOutput("t5_write_count", wr_count - wr_base, 0);
        checkOutput("t5_storage", mem[3][12'hC00], 32'h42);

        // Read CSR_LTID (old 2) with commit back-pressure for 3 cycles
        wr_base = wr_count;
        applyStimulus(2'd1, 4'hF, 32'h6000, 5'd6, 1'b1, 2'd1, 12'hCC1, 32'd0);
        @(negedge clk);
        applyIdle();
        cmt_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checkOutput("t6_hold_valid", cmt_valid, 1);
            checkOutput("t6_hold_data", cmt_data, {32'd11, 32'd10, 32'd9, 32'd8});
            checkOutput("t6_hold_pc", cmt_pc, 32'h6000);
            checkOutput("t6_hold_pending", pending[1], 1);
            checkOutput("t6_illegal", cmt_illegal, 0);
        end
        cmt_ready = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("t6_done", cmt_valid, 0);
        checkOutput("t6_pending_clear", pending[1], 0);
        checkOutput("t6_no_write", wr_count - wr_base, 0);

        // Reset with an op in flight drops it without a write
        @(negedge clk);
        wr_base = wr_count;
        applyStimulus(2'd0, 4'h1, 32'h7000, 5'd8, 1'b1, 2'd0, 12'h307, 32'h55);
        @(negedge clk);
        applyIdle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("t7_pending_clear", pending, 0);
        checkOutput("t7_cmt_valid", cmt_valid, 0);
        repeat (3) @(negedge clk);
        checkOutput("t7_no_cmt", cmt_valid, 0);
        checkOutput("t7_no_write", wr_count - wr_base, 0);
        checkOutput("t7_storage", mem[0][12'h307], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
